// File: rtl/btr_pkg.sv
// Shared types and helpers for the bit-reversal reorder sequencer.
package btr_pkg;

  localparam int MAX_LOG2N = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_RD_A,
    ST_RD_B,
    ST_CAP,
    ST_WR_A,
    ST_WR_B,
    ST_DONE
  } btr_state_e;

  // Size exponents beyond the address width would index past the buffer.
  function automatic logic [4:0] clamp_log2n(input logic [4:0] v, input int max_v);
    return (int'(v) > max_v) ? 5'(max_v) : v;
  endfunction

endpackage

// File: rtl/btr_idx_gen.sv
// Partner index generator: full-width bit reverse of idx, right-aligned to log2n bits.
module btr_idx_gen #(
  parameter int AW = 16
) (
  input  logic [AW-1:0] idx,
  input  logic [4:0]    log2n,
  output logic [AW-1:0] rev_idx
);

  logic [AW-1:0] rev_full;
  logic [5:0]    sh;

  for (genvar b = 0; b < AW; b++) begin : g_rev
    assign rev_full[b] = idx[AW-1-b];
  end

  // log2n = 0 shifts by the full width, giving partner 0.
  assign sh      = 6'(AW) - {1'b0, log2n};
  assign rev_idx = rev_full >> sh;

endmodule

// File: rtl/btr_reorder_ctrl.sv
// In-place bit-reversal permutation sequencer over a shared single-port memory.
// Optional early termination via BTRCTL_ABORT_EN (abort input, aborted output).
module btr_reorder_ctrl
  import btr_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [4:0]    log2n,
  output logic          busy,
  output logic          done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic [DW-1:0] mem_rdata
`ifdef BTRCTL_ABORT_EN
  ,
  input  logic          abort,
  output logic          aborted
`endif
);

  btr_state_e    state_q, state_d;
  logic [AW:0]   i_q, i_d;
  logic [4:0]    log2n_q, log2n_d;
  logic [DW-1:0] reg_a_q, reg_a_d;
  logic [DW-1:0] reg_b_q, reg_b_d;
  logic          rd_vld_q, rd_vld_d;
  logic [AW-1:0] j;
  logic [AW:0]   n_val;
  logic          stop_req;

`ifdef BTRCTL_ABORT_EN
  logic abort_pend_q, abort_pend_d;
  assign stop_req = abort_pend_q;
`else
  assign stop_req = 1'b0;
`endif

  btr_idx_gen #(.AW(AW)) u_idx_gen (
    .idx    (i_q[AW-1:0]),
    .log2n  (log2n_q),
    .rev_idx(j)
  );

  assign n_val = {{AW{1'b0}}, 1'b1} << log2n_q;

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    log2n_d  = log2n_q;
    reg_a_d  = reg_a_q;
    reg_b_d  = reg_b_q;
    rd_vld_d = 1'b0;
`ifdef BTRCTL_ABORT_EN
    abort_pend_d = abort_pend_q;
`endif
    // The A word lands one cycle after its grant, whatever RD_B is doing.
    if (rd_vld_q) reg_a_d = mem_rdata;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          log2n_d = clamp_log2n(log2n, AW);
          i_d     = '0;
          state_d = ST_SCAN;
`ifdef BTRCTL_ABORT_EN
          abort_pend_d = 1'b0;
`endif
        end
      end
      ST_SCAN: begin
        if (i_q == n_val || stop_req) state_d = ST_DONE;
        else if (i_q < {1'b0, j})     state_d = ST_RD_A;
        else                          i_d     = i_q + 1'b1;
      end
      ST_RD_A: begin
        if (mem_gnt) begin
          rd_vld_d = 1'b1;
          state_d  = ST_RD_B;
        end
      end
      ST_RD_B: if (mem_gnt) state_d = ST_CAP;
      ST_CAP: begin
        reg_b_d = mem_rdata;
        state_d = ST_WR_A;
      end
      ST_WR_A: if (mem_gnt) state_d = ST_WR_B;
      ST_WR_B: begin
        if (mem_gnt) begin
          i_d     = i_q + 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef BTRCTL_ABORT_EN
        abort_pend_d = 1'b0;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef BTRCTL_ABORT_EN
    if (busy && abort) abort_pend_d = 1'b1;
`endif
  end

  // Memory-side outputs decode registered state only, so gnt never reaches them.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ST_RD_A: begin
        mem_req  = 1'b1;
        mem_addr = i_q[AW-1:0];
      end
      ST_RD_B: begin
        mem_req  = 1'b1;
        mem_addr = j;
      end
      ST_WR_A: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = i_q[AW-1:0];
        mem_wdata = reg_b_q;
      end
      ST_WR_B: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = j;
        mem_wdata = reg_a_q;
      end
      default: ;
    endcase
  end

  assign busy = (state_q == ST_SCAN) || (state_q == ST_RD_A) || (state_q == ST_RD_B) ||
                (state_q == ST_CAP)  || (state_q == ST_WR_A) || (state_q == ST_WR_B);
  assign done = (state_q == ST_DONE);

`ifdef BTRCTL_ABORT_EN
  assign aborted = done && abort_pend_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      i_q      <= '0;
      log2n_q  <= '0;
      reg_a_q  <= '0;
      reg_b_q  <= '0;
      rd_vld_q <= 1'b0;
`ifdef BTRCTL_ABORT_EN
      abort_pend_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      log2n_q  <= log2n_d;
      reg_a_q  <= reg_a_d;
      reg_b_q  <= reg_b_d;
      rd_vld_q <= rd_vld_d;
`ifdef BTRCTL_ABORT_EN
      abort_pend_q <= abort_pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_btr_reorder_ctrl.sv
// Bench for btr_reorder_ctrl: memory model, access scoreboard, table-driven runs.
module tb_btr_reorder_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  log2n_i = '0;
  logic        busy, done, mem_req, mem_we, mem_gnt;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef BTRCTL_ABORT_EN
  logic        abort = 1'b0;
  logic        aborted;
`endif

  btr_reorder_ctrl #(.DW(16), .AW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .log2n(log2n_i),
    .busy(busy), .done(done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata)
`ifdef BTRCTL_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
  } acc_t;

  typedef struct {
    int          log2n;
    bit          rnd;
    logic [15:0] base;
    int          exp_done;
    int          exp_swaps;
  } vec_t;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] mem [256];
  acc_t        sb_q[$];
  bit          sb_en = 1'b0;
  bit          gnt_rnd = 1'b0;
  int          acc_cnt = 0;
  int          req_cyc = 0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_addr, prev_wdata;
  logic        prev_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int brev(input int v, input int l);
    int r = 0;
    for (int b = 0; b < l; b++)
      if (((v >> b) & 1) != 0) r |= (1 << (l - 1 - b));
    return r;
  endfunction

  task automatic init_mem(input logic [15:0] base);
    for (int k = 0; k < 256; k++) mem[k] = base + 16'(k);
  endtask

  // Memory model: read data is valid the cycle after a granted read.
  always @(posedge clk) begin
    if (mem_req === 1'b1 && mem_gnt === 1'b1) begin
      if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end else begin
      mem_rdata <= 16'hBAD0;
    end
  end

  always @(posedge clk) begin
    #1;
    mem_gnt = gnt_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (sb_en) begin
      if (mem_req) req_cyc++;
      if (prev_stall && mem_req) begin
        chk("stall_addr", 32'(mem_addr), 32'(prev_addr));
        chk("stall_we", 32'(mem_we), 32'(prev_we));
        chk("stall_wdata", 32'(mem_wdata), 32'(prev_wdata));
      end
      if (mem_req && mem_gnt) begin
        acc_cnt++;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_access: got addr %h we %b, expected no access", mem_addr, mem_we);
        end else begin
          acc_t e;
          e = sb_q.pop_front();
          chk("acc_addr", 32'(mem_addr), 32'(e.addr));
          chk("acc_we", 32'(mem_we), 32'(e.we));
          if (e.we) chk("acc_wdata", 32'(mem_wdata), 32'(e.wdata));
        end
      end
    end
    prev_stall = mem_req && !mem_gnt;
    prev_addr  = mem_addr;
    prev_we    = mem_we;
    prev_wdata = mem_wdata;
  end

  task automatic push_swap(input int i, input int j, input logic [15:0] base);
    acc_t a;
    a.addr = 16'(i); a.we = 1'b0; a.wdata = '0;         sb_q.push_back(a);
    a.addr = 16'(j);                                    sb_q.push_back(a);
    a.addr = 16'(i); a.we = 1'b1; a.wdata = base + 16'(j); sb_q.push_back(a);
    a.addr = 16'(j);              a.wdata = base + 16'(i); sb_q.push_back(a);
  endtask

  task automatic pulse_start(input int l);
    @(negedge clk);
    start   = 1'b1;
    log2n_i = 5'(l);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns the cycle (after the start edge) in which done was seen, 0 on timeout.
  task automatic wait_done(output int done_at);
    done_at = 0;
    for (int cnt = 1; cnt <= 3000; cnt++) begin
      @(negedge clk);
      if (cnt == 1) chk("busy_cycle1", 32'(busy), 32'd1);
      if (done) begin
        done_at = cnt;
        break;
      end
    end
    if (done_at == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done in 3000 cycles, expected done");
    end
  endtask

  task automatic run(input vec_t r);
    int n, done_at;
    init_mem(r.base);
    gnt_rnd = r.rnd;
    sb_q.delete();
    acc_cnt = 0;
    req_cyc = 0;
    n = 1 << r.log2n;
    for (int i = 0; i < n; i++) begin
      int j;
      j = brev(i, r.log2n);
      if (i < j) push_swap(i, j, r.base);
    end
    sb_en = 1'b1;
    pulse_start(r.log2n);
    wait_done(done_at);
    if (done_at != 0) begin
      chk("busy_at_done", 32'(busy), 32'd0);
      if (r.exp_done != 0) chk("done_cycle", 32'(done_at), 32'(r.exp_done));
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
    end
    sb_en = 1'b0;
    gnt_rnd = 1'b0;
    chk("access_count", 32'(acc_cnt), 32'(4 * r.exp_swaps));
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    if (r.exp_swaps == 0) chk("no_req", 32'(req_cyc), 32'd0);
    for (int k = 0; k < n; k++)
      chk($sformatf("mem[%0d]", k), 32'(mem[k]), 32'(r.base + 16'(brev(k, r.log2n))));
    if (n < 256) chk("mem_above_n", 32'(mem[n]), 32'(r.base + 16'(n)));
  endtask

  vec_t vecs[7];

  initial begin
    int done_at;
    bit hit;
    vecs[0] = '{log2n: 3, rnd: 1'b0, base: 16'h0000, exp_done: 20, exp_swaps: 2};
    vecs[1] = '{log2n: 4, rnd: 1'b0, base: 16'h0000, exp_done: 48, exp_swaps: 6};
    vecs[2] = '{log2n: 3, rnd: 1'b1, base: 16'h5A00, exp_done: 0,  exp_swaps: 2};
    vecs[3] = '{log2n: 0, rnd: 1'b0, base: 16'h1200, exp_done: 3,  exp_swaps: 0};
    vecs[4] = '{log2n: 1, rnd: 1'b0, base: 16'h1300, exp_done: 4,  exp_swaps: 0};
    vecs[5] = '{log2n: 2, rnd: 1'b0, base: 16'h2400, exp_done: 11, exp_swaps: 1};
    vecs[6] = '{log2n: 4, rnd: 1'b1, base: 16'h7700, exp_done: 0,  exp_swaps: 6};

    init_mem(16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
`ifdef BTRCTL_ABORT_EN
    chk("rst_aborted", 32'(aborted), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[v]) run(vecs[v]);

    // Reset while the first WR_A is on the bus.
    init_mem(16'h3300);
    pulse_start(3);
    hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (mem_req && mem_we) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reached_wr_a", 32'(hit), 32'd1);
    chk("wr_a_addr", 32'(mem_addr), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(vecs[0]);

`ifdef BTRCTL_ABORT_EN
    init_mem(16'h4400);
    sb_q.delete();
    acc_cnt = 0;
    push_swap(1, 8, 16'h4400);
    sb_en = 1'b1;
    pulse_start(4);
    hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_addr == 16'd8) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reached_rd_b", 32'(hit), 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    done_at = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done) begin
        done_at = c + 1;
        break;
      end
    end
    chk("abort_done_seen", 32'(done_at != 0), 32'd1);
    chk("abort_flag", 32'(aborted), 32'd1);
    // done was at cycle 9 after start; the RD_B detection negedge is cycle 4.
    chk("abort_done_cycle", 32'(done_at + 4), 32'd9);
    @(negedge clk);
    chk("aborted_one_cycle", 32'(aborted), 32'd0);
    sb_en = 1'b0;
    chk("abort_acc_count", 32'(acc_cnt), 32'd4);
    chk("abort_mem1", 32'(mem[1]), 32'(16'h4408));
    chk("abort_mem8", 32'(mem[8]), 32'(16'h4401));
    chk("abort_mem2", 32'(mem[2]), 32'(16'h4402));
`else
    done_at = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
